// File: rtl/command_encoder.sv
// command_encoder
//   Packs decoded instruction fields (R/I/J formats) into 32-bit command
//   words, buffers them in a small FIFO and tags each entry with an
//   instruction-memory write address taken from an internal counter.
//
// Ports
//   clk, reset        : clock (rising edge) and synchronous active-high reset
//   in_valid/in_ready : input handshake for the field tuple on in_*
//   in_op_code..in_address : decoded instruction fields
//   addr_load/addr_load_val : overwrite the write-address counter
//   out_valid/out_ready : output handshake for the FIFO head
//   out_word, out_addr, out_format : head entry (word, address, format)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. valid never depends on ready, in_ready depends only on the
// registered occupancy (no path from out_ready), and an offered tuple is
// held on the inputs until it is taken.
module command_encoder #(
    parameter int DEPTH     = 2,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_STEP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op_code,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_ws,
    input  logic [15:0]       in_imm,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [25:0]       in_address,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_load_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic [1:0]        out_format
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_J = 2'd2;

    logic [31:0]       mem_word   [DEPTH];
    logic [ADDR_W-1:0] mem_addr   [DEPTH];
    logic [1:0]        mem_format [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] wr_addr;

    // Last presented head; shown while the FIFO is empty.
    logic [31:0]       hold_word;
    logic [ADDR_W-1:0] hold_addr;
    logic [1:0]        hold_format;

    logic [31:0]       enc_word;
    logic [1:0]        enc_format;
    logic [ADDR_W-1:0] push_addr;
    logic              push;
    logic              pop;

    // Format comes from the opcode alone; unused fields never reach the word.
    always_comb begin
        enc_format = FMT_I;
        enc_word   = {in_op_code, in_rs1, in_rs2, in_imm};
        case (in_op_code)
            6'b000000, 6'b010000: begin
                enc_format = FMT_R;
                enc_word   = {in_op_code, in_rs1, in_rs2, in_ws, in_shamt, in_funct};
            end
            6'b000010, 6'b010011: begin
                enc_format = FMT_J;
                enc_word   = {in_op_code, in_address};
            end
            default: ;
        endcase
    end

    assign in_ready  = (count < DEPTH_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // A load in the same cycle as a push tags that push with the new value.
    assign push_addr = addr_load ? addr_load_val : wr_addr;

    assign out_word   = out_valid ? mem_word[rd_ptr]   : hold_word;
    assign out_addr   = out_valid ? mem_addr[rd_ptr]   : hold_addr;
    assign out_format = out_valid ? mem_format[rd_ptr] : hold_format;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wr_addr     <= BASE;
            hold_word   <= '0;
            hold_addr   <= '0;
            hold_format <= '0;
        end else begin
            if (push) begin
                mem_word[wr_ptr]   <= enc_word;
                mem_addr[wr_ptr]   <= push_addr;
                mem_format[wr_ptr] <= enc_format;
                wr_ptr             <= wr_ptr + PTR_W'(1);
                wr_addr            <= push_addr + STEP;
            end else if (addr_load) begin
                wr_addr <= addr_load_val;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            if (out_valid) begin
                hold_word   <= mem_word[rd_ptr];
                hold_addr   <= mem_addr[rd_ptr];
                hold_format <= mem_format[rd_ptr];
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_command_encoder.sv
module tb_command_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op_code;
    logic [4:0]  in_rs1, in_rs2, in_ws, in_shamt;
    logic [15:0] in_imm;
    logic [5:0]  in_funct;
    logic [25:0] in_address;
    logic        addr_load;
    logic [9:0]  addr_load_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [9:0]  out_addr;
    logic [1:0]  out_format;

    int checks = 0;
    int errors = 0;

    logic [43:0] exp_q[$];      // {word, addr, format}
    logic [9:0]  got_addr_q[$]; // addresses of popped entries, in order
    logic [9:0]  model_addr;

    command_encoder dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op_code(in_op_code), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_ws(in_ws),
        .in_imm(in_imm), .in_shamt(in_shamt), .in_funct(in_funct), .in_address(in_address),
        .addr_load(addr_load), .addr_load_val(addr_load_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr), .out_format(out_format)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [1:0] ref_format(input logic [5:0] op);
        if (op == 6'd0 || op == 6'd16) return 2'd0;
        if (op == 6'd2 || op == 6'd19) return 2'd2;
        return 2'd1;
    endfunction

    function automatic logic [31:0] ref_word(input logic [5:0] op, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [4:0] ws, input logic [15:0] imm,
        input logic [4:0] shamt, input logic [5:0] funct, input logic [25:0] adr);
        logic [31:0] w;
        w = 32'(op) << 26;
        case (ref_format(op))
            2'd0: w = w | (32'(rs1) << 21) | (32'(rs2) << 16) | (32'(ws) << 11)
                        | (32'(shamt) << 6) | 32'(funct);
            2'd2: w = w | 32'(adr);
            default: w = w | (32'(rs1) << 21) | (32'(rs2) << 16) | 32'(imm);
        endcase
        return w;
    endfunction

    // ---------------- scoreboard / monitor (mid-cycle sampling) ----------------
    always @(negedge clk) begin
        logic [43:0] e;
        logic [9:0]  a;
        if (reset) begin
            exp_q.delete();
            model_addr = 10'd0;
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                got_addr_q.push_back(out_addr);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got word=%h addr=%h fmt=%0d with nothing expected",
                             out_word, out_addr, out_format);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_word, out_addr, out_format} !== e) begin
                        errors++;
                        $display("FAIL sb_entry: got word=%h addr=%h fmt=%0d expected word=%h addr=%h fmt=%0d",
                                 out_word, out_addr, out_format, e[43:12], e[11:2], e[1:0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                a = addr_load ? addr_load_val : model_addr;
                exp_q.push_back({ref_word(in_op_code, in_rs1, in_rs2, in_ws, in_imm, in_shamt,
                                          in_funct, in_address), a, ref_format(in_op_code)});
                model_addr = a + 10'd1;
            end else if (addr_load) begin
                model_addr = addr_load_val;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [5:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [4:0] ws, input logic [15:0] imm, input logic [4:0] shamt,
        input logic [5:0] funct, input logic [25:0] adr);
        in_op_code = op; in_rs1 = rs1; in_rs2 = rs2; in_ws = ws;
        in_imm = imm; in_shamt = shamt; in_funct = funct; in_address = adr;
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [4:0] ws, input logic [15:0] imm, input logic [4:0] shamt,
        input logic [5:0] funct, input logic [25:0] adr, input logic load, input logic [9:0] lval);
        bit accepted = 0;
        set_fields(op, rs1, rs2, ws, imm, shamt, funct, adr);
        in_valid = 1'b1;
        addr_load = load;
        addr_load_val = lval;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            accepted = in_ready;
            tick();
        end
        in_valid = 1'b0;
        addr_load = 1'b0;
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1 within 50 cycles", in_ready);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        got_addr_q.delete();
    endtask

    task automatic wait_drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
    endtask

    task automatic check_head(input string name, input logic [31:0] w, input logic [9:0] a,
                              input logic [1:0] f);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_word !== w || out_addr !== a || out_format !== f) begin
            errors++;
            $display("FAIL %s: valid=%b word=%h addr=%h fmt=%0d required valid=1 word=%h addr=%h fmt=%0d",
                     name, out_valid, out_word, out_addr, out_format, w, a, f);
        end
        tick();
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_word !== 32'h0 ||
            out_addr !== 10'h0 || out_format !== 2'd0) begin
            errors++;
            $display("FAIL %s: valid=%b ready=%b word=%h addr=%h fmt=%0d required 0 1 0 0 0",
                     name, out_valid, in_ready, out_word, out_addr, out_format);
        end
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        check_idle("reset_state");
    endtask

    task automatic test_r_type();
        do_reset();
        out_ready = 1'b1;
        send(6'd0, 5'd1, 5'd2, 5'd3, 16'hFFFF, 5'd0, 6'h20, 26'h3FFFFFF, 1'b0, 10'd0);
        check_head("r_type", 32'h00221820, 10'd0, 2'd0);
    endtask

    task automatic test_i_j_types();
        do_reset();
        out_ready = 1'b1;
        send(6'b001000, 5'd1, 5'd2, 5'd31, 16'hFFFF, 5'd7, 6'h3F, 26'h155AAAA, 1'b0, 10'd0);
        check_head("i_type", 32'h2022FFFF, 10'd0, 2'd1);
        send(6'b000010, 5'd31, 5'd31, 5'd31, 16'hFFFF, 5'd31, 6'h3F, 26'h0000100, 1'b0, 10'd0);
        check_head("j_type", 32'h08000100, 10'd1, 2'd2);
    endtask

    task automatic test_alt_opcodes();
        do_reset();
        out_ready = 1'b1;
        send(6'b010000, 5'd0, 5'd0, 5'd0, 16'h0, 5'd0, 6'h3F, 26'h0, 1'b0, 10'd0);
        check_head("alt_r", 32'h4000003F, 10'd0, 2'd0);
        send(6'b010011, 5'd31, 5'd31, 5'd31, 16'hFFFF, 5'd31, 6'h3F, 26'h3FFFFFF, 1'b0, 10'd0);
        check_head("alt_j", 32'h4FFFFFFF, 10'd1, 2'd2);
    endtask

    task automatic test_back_to_back();
        bit acc = 0;
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_fields(6'd8, 5'd1, 5'd1, 5'd0, 16'h0001, 5'd0, 6'd0, 26'd0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first: in_ready=%b required 1", in_ready); end
        tick();
        set_fields(6'd8, 5'd2, 5'd2, 5'd0, 16'h0002, 5'd0, 6'd0, 26'd0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_second: in_ready=%b required 1", in_ready); end
        tick();
        set_fields(6'd8, 5'd3, 5'd3, 5'd0, 16'h0003, 5'd0, 6'd0, 26'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_word !== 32'h20210001) begin
                errors++;
                $display("FAIL bp_full: in_ready=%b head=%h required 0 20210001", in_ready, out_word);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        wait_drain();
        checks++;
        if (got_addr_q.size() != 3 || got_addr_q[0] !== 10'd0 || got_addr_q[1] !== 10'd1 ||
            got_addr_q[2] !== 10'd2) begin
            errors++;
            $display("FAIL bp_order: got %0d entries first_addr=%h required 3 entries addr 0,1,2",
                     got_addr_q.size(), got_addr_q.size() != 0 ? got_addr_q[0] : 10'h3FF);
        end
    endtask

    task automatic test_addr_control();
        do_reset();
        out_ready = 1'b1;
        addr_load = 1'b1;
        addr_load_val = 10'd1023;
        tick();
        addr_load = 1'b0;
        send(6'd8, 5'd1, 5'd2, 5'd0, 16'h1111, 5'd0, 6'd0, 26'd0, 1'b0, 10'd0);
        send(6'd8, 5'd1, 5'd2, 5'd0, 16'h2222, 5'd0, 6'd0, 26'd0, 1'b0, 10'd0);
        send(6'd0, 5'd4, 5'd5, 5'd6, 16'h0, 5'd7, 6'h21, 26'd0, 1'b1, 10'h100);
        send(6'd2, 5'd0, 5'd0, 5'd0, 16'h0, 5'd0, 6'd0, 26'h0ABCDEF, 1'b0, 10'd0);
        wait_drain();
        checks++;
        if (got_addr_q.size() != 4 || got_addr_q[0] !== 10'd1023 || got_addr_q[1] !== 10'd0 ||
            got_addr_q[2] !== 10'h100 || got_addr_q[3] !== 10'h101) begin
            errors++;
            $display("FAIL addr_ctrl: got %0d entries, required 4 with addr 3ff,000,100,101",
                     got_addr_q.size());
        end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        out_ready = 1'b0;
        send(6'd8, 5'd1, 5'd1, 5'd0, 16'hAAAA, 5'd0, 6'd0, 26'd0, 1'b0, 10'd0);
        send(6'd8, 5'd2, 5'd2, 5'd0, 16'hBBBB, 5'd0, 6'd0, 26'd0, 1'b0, 10'd0);
        set_fields(6'd8, 5'd3, 5'd3, 5'd0, 16'hCCCC, 5'd0, 6'd0, 26'd0);
        in_valid = 1'b1;   // offered during reset: must be dropped
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        check_idle("reset_mid");
        got_addr_q.delete();
        out_ready = 1'b1;
        send(6'd2, 5'd0, 5'd0, 5'd0, 16'h0, 5'd0, 6'd0, 26'h0000042, 1'b0, 10'd0);
        wait_drain();
        checks++;
        if (got_addr_q.size() != 1 || got_addr_q[0] !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid_addr: got %0d entries, required 1 at addr 0", got_addr_q.size());
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[6] = '{6'd0, 6'd16, 6'd2, 6'd19, 6'd8, 6'd35};
        logic [5:0] op;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            out_ready = (exp_q.size() >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
            op = ($urandom_range(0, 1) == 0) ? ops[$urandom_range(0, 5)] : 6'($urandom_range(0, 63));
            send(op, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 5'($urandom),
                 6'($urandom), 26'($urandom), 1'($urandom_range(0, 7) == 0), 10'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        wait_drain();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        addr_load = 1'b0; addr_load_val = '0;
        set_fields(6'd0, 5'd0, 5'd0, 5'd0, 16'h0, 5'd0, 6'd0, 26'd0);
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_r_type();
        test_i_j_types();
        test_alt_opcodes();
        test_back_to_back();
        test_addr_control();
        test_reset_mid_stream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
